// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event unit.
//   btn_state_e : per-button debounce / auto-repeat FSM states
//   CODE_*      : EvtCode values, one per button (bit index in Btn)
//   btn_code()  : button index -> EvtCode
//   cnt_width() : width of the shared per-button debounce/repeat counter
package btn_event_pkg;

  localparam int N_BTN = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PDEB = 3'd1,
    ST_HELD = 3'd2,
    ST_RPT  = 3'd3,
    ST_RDEB = 3'd4
  } btn_state_e;

  localparam logic [2:0] CODE_R = 3'd0;
  localparam logic [2:0] CODE_L = 3'd1;
  localparam logic [2:0] CODE_D = 3'd2;
  localparam logic [2:0] CODE_U = 3'd3;
  localparam logic [2:0] CODE_C = 3'd4;

  function automatic logic [2:0] btn_code(input int idx);
    case (idx)
      1:       return CODE_L;
      2:       return CODE_D;
      3:       return CODE_U;
      4:       return CODE_C;
      default: return CODE_R;
    endcase
  endfunction

  // One counter serves debounce, repeat delay and repeat period, so it
  // must be wide enough for the largest of the three.
  function automatic int cnt_width(input int n_dc, input int dly, input int per);
    int w;
    w = n_dc;
    if ($clog2(dly) > w) w = $clog2(dly);
    if ($clog2(per) > w) w = $clog2(per);
    return w;
  endfunction

endpackage

// File: rtl/btn_event_unit_chan.sv
// btn_chan: one button channel.
//   Clk, Reset : system clock, synchronous active-high reset
//   i_btn      : raw asynchronous button level
//   o_pulse    : one-cycle raw event (first press and auto-repeat)
//   o_held     : debounced level (HELD, RPT or RDEB)
module btn_chan
  import btn_event_pkg::*;
#(
  parameter int   N_DC    = 20,
  parameter int   RPT_DLY = 50_000_000,
  parameter int   RPT_PER = 15_000_000,
  parameter logic RPT_EN  = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_held
);

  localparam int CNT_W = cnt_width(N_DC, RPT_DLY, RPT_PER);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'((64'd1 << N_DC) - 64'd1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PER - 1);

  logic [1:0]       r_sync;
  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             w_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  assign w_in = r_sync[1];

  // Stage: 2-flop synchronizer, FSM state, counter and raw pulse register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync  <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = sat_inc(r_cnt);
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_in) w_state_nxt = ST_PDEB;
      end
      ST_PDEB: begin
        if (!w_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_in) begin
          w_state_nxt = ST_RDEB;
          w_cnt_nxt   = '0;
        end else if (RPT_EN && (r_cnt == DLY_LAST)) begin
          w_state_nxt = ST_RPT;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end
      end
      ST_RPT: begin
        if (!w_in) begin
          w_state_nxt = ST_RDEB;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end
      end
      ST_RDEB: begin
        // A rejoin inside the release window is a bounce: resume holding
        // with a fresh repeat delay and no new event.
        if (w_in) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_held  = (r_state == ST_HELD) || (r_state == ST_RPT) || (r_state == ST_RDEB);

endmodule

// File: rtl/btn_event_unit.sv
// btn_event_unit: debounced, auto-repeating button events for the game core.
//   Clk, Reset           : system clock, synchronous active-high reset
//   Btn[4:0]             : raw buttons {C,U,D,L,R}
//   Select/Up/Down/Left/Right : one-cycle event pulses (at most one per cycle)
//   Evt, EvtCode[2:0]    : any-event flag and code of the pulsed button
//   Held[4:0]            : debounced button levels, same order as Btn
module btn_event_unit
  import btn_event_pkg::*;
#(
  parameter int               N_DC    = 20,
  parameter int               RPT_DLY = 50_000_000,
  parameter int               RPT_PER = 15_000_000,
  parameter logic [N_BTN-1:0] RPT_EN  = 5'b01111
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn,
  output logic             Select,
  output logic             Up,
  output logic             Down,
  output logic             Left,
  output logic             Right,
  output logic             Evt,
  output logic [2:0]       EvtCode,
  output logic [N_BTN-1:0] Held
);

  logic [N_BTN-1:0] w_raw, w_held, w_win;
  logic [2:0]       w_code;
  logic             w_any;
  logic [N_BTN-1:0] r_vec, r_held;
  logic [2:0]       r_code;
  logic             r_evt;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_chan #(
      .N_DC    (N_DC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER),
      .RPT_EN  (RPT_EN[gi])
    ) u_chan (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_btn   (Btn[gi]),
      .o_pulse (w_raw[gi]),
      .o_held  (w_held[gi])
    );
  end

  // Higher bit index wins; losing pulses of the same cycle are discarded.
  always_comb begin
    w_win  = '0;
    w_code = CODE_R;
    w_any  = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_raw[3'(i)]) begin
        w_win  = N_BTN'(1) << i;
        w_code = btn_code(i);
        w_any  = 1'b1;
      end
    end
  end

  // Stage: output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vec  <= '0;
      r_evt  <= 1'b0;
      r_code <= '0;
      r_held <= '0;
    end else begin
      r_vec  <= w_win;
      r_evt  <= w_any;
      r_code <= w_code;
      r_held <= w_held;
    end
  end

  assign {Select, Up, Down, Left, Right} = r_vec;
  assign Evt     = r_evt;
  assign EvtCode = r_code;
  assign Held    = r_held;

endmodule

// File: tb/tb_btn_event_unit.sv
module tb_btn_event_unit;

  localparam int         N_DC    = 4;
  localparam int         RPT_DLY = 40;
  localparam int         RPT_PER = 10;
  localparam logic [4:0] RPT_EN  = 5'b01111;
  localparam int         DB      = 1 << N_DC;

  localparam int P_IDLE = 0, P_PDEB = 1, P_HELD = 2, P_RPT = 3, P_RDEB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] Btn = '0;
  logic       Select, Up, Down, Left, Right, Evt;
  logic [2:0] EvtCode;
  logic [4:0] Held;
  logic [4:0] obs_p;

  assign obs_p = {Select, Up, Down, Left, Right};

  btn_event_unit #(
    .N_DC(N_DC), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_EN(RPT_EN)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Btn(Btn),
    .Select(Select), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .Evt(Evt), .EvtCode(EvtCode), .Held(Held)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each button is described by the phase named in the
  // requirements and the edge at which it entered that phase; events fire
  // when the time spent in a phase reaches the stated duration.
  int         ph  [5];
  int         ent [5];
  bit         s1  [5];
  bit         s2  [5];
  bit         raw [5];
  int         mc = 0;
  logic [4:0] e_p = '0;
  logic       e_evt = 1'b0;
  logic [2:0] e_code = '0;
  logic [4:0] e_held = '0;

  task automatic model_update(input logic [4:0] b, input logic r);
    bit s;
    int age;
    mc++;
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        ph[i] = P_IDLE; ent[i] = mc; s1[i] = 0; s2[i] = 0; raw[i] = 0;
      end
      e_p = '0; e_evt = 1'b0; e_code = '0; e_held = '0;
    end else begin
      e_p = '0; e_evt = 1'b0; e_code = '0;
      for (int i = 4; i >= 0; i--) begin
        if (raw[i] && !e_evt) begin
          e_p[3'(i)] = 1'b1; e_evt = 1'b1; e_code = 3'(i);
        end
      end
      for (int i = 0; i < 5; i++)
        e_held[3'(i)] = (ph[i] == P_HELD) || (ph[i] == P_RPT) || (ph[i] == P_RDEB);
      for (int i = 0; i < 5; i++) begin
        raw[i] = 0;
        s   = s2[i];
        age = mc - ent[i];
        case (ph[i])
          P_IDLE: if (s) begin ph[i] = P_PDEB; ent[i] = mc; end
          P_PDEB: begin
            if (!s) ph[i] = P_IDLE;
            else if (age == DB) begin ph[i] = P_HELD; ent[i] = mc; raw[i] = 1; end
          end
          P_HELD: begin
            if (!s) begin ph[i] = P_RDEB; ent[i] = mc; end
            else if (RPT_EN[3'(i)] && age == RPT_DLY) begin ph[i] = P_RPT; ent[i] = mc; raw[i] = 1; end
          end
          P_RPT: begin
            if (!s) begin ph[i] = P_RDEB; ent[i] = mc; end
            else if (age == RPT_PER) begin ent[i] = mc; raw[i] = 1; end
          end
          default: begin
            if (s) begin ph[i] = P_HELD; ent[i] = mc; end
            else if (age == DB) ph[i] = P_IDLE;
          end
        endcase
        s2[i] = s1[i];
        s1[i] = b[3'(i)];
      end
    end
  endtask

  task automatic step();
    model_update(Btn, Reset);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Btn = '0;
    step(); step();
    Reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Btn = 5'($urandom);
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== 13'd0) begin
        n_bad++; $display("FAIL reset_outputs k=%0d got=%b want=0", k, {obs_p, Evt, EvtCode, Held});
      end
    end
    Reset = 1'b0; Btn = '0;
    repeat (3) step();
  endtask

  task automatic test_press_up();
    logic [127:0] pm, xm;
    int fall;
    do_reset();
    pm = '0; fall = -1;
    for (int k = 0; k < 90; k++) begin
      Btn = (k < 30) ? 5'b01000 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL press_up_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Up) pm[7'(k)] = 1'b1;
      if (k == 19) begin
        n_cmp++;
        if ({Evt, EvtCode} !== 4'b1011) begin
          n_bad++; $display("FAIL press_up_code got=%b want=1011", {Evt, EvtCode});
        end
      end
      if (k > 30 && fall < 0 && !Held[3]) fall = k;
    end
    xm = '0; xm[19] = 1'b1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL press_up_pulses got=%h want=%h", pm, xm); end
    n_cmp++;
    if (fall !== 49) begin n_bad++; $display("FAIL press_up_held_clear got=%0d want=49", fall); end
  endtask

  task automatic test_glitch();
    int nev, nheld;
    do_reset();
    nev = 0; nheld = 0;
    for (int k = 0; k < 40; k++) begin
      Btn = (k < 10) ? 5'b00010 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL glitch_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Evt || (obs_p != 0)) nev++;
      if (Held != 0) nheld++;
    end
    n_cmp++;
    if (nev !== 0) begin n_bad++; $display("FAIL glitch_events got=%0d want=0", nev); end
    n_cmp++;
    if (nheld !== 0) begin n_bad++; $display("FAIL glitch_held got=%0d want=0", nheld); end
  endtask

  task automatic test_repeat();
    logic [127:0] pm, xm;
    do_reset();
    pm = '0;
    for (int k = 0; k < 128; k++) begin
      Btn = (k < 100) ? 5'b00001 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL repeat_r_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Right) pm[7'(k)] = 1'b1;
    end
    xm = '0; xm[19] = 1; xm[59] = 1; xm[69] = 1; xm[79] = 1; xm[89] = 1; xm[99] = 1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL repeat_r_pulses got=%h want=%h", pm, xm); end
    do_reset();
    pm = '0;
    for (int k = 0; k < 128; k++) begin
      Btn = (k < 100) ? 5'b10000 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL repeat_c_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Select) pm[7'(k)] = 1'b1;
    end
    xm = '0; xm[19] = 1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL repeat_c_pulses got=%h want=%h", pm, xm); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pc, pd, xm;
    do_reset();
    pc = '0; pd = '0;
    for (int k = 0; k < 60; k++) begin
      Btn = (k < 30) ? 5'b10100 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL same_cycle_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Select) pc[7'(k)] = 1'b1;
      if (Down) pd[7'(k)] = 1'b1;
    end
    xm = '0; xm[19] = 1;
    n_cmp++;
    if (pc !== xm) begin n_bad++; $display("FAIL same_cycle_select got=%h want=%h", pc, xm); end
    n_cmp++;
    if (pd !== 128'd0) begin n_bad++; $display("FAIL same_cycle_down got=%h want=0", pd); end
  endtask

  task automatic test_bounce();
    logic [127:0] pm, xm;
    do_reset();
    pm = '0;
    for (int k = 0; k < 120; k++) begin
      Btn = ((k < 30) || (k >= 35 && k < 100)) ? 5'b01000 : 5'b00000;
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL bounce_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Up) pm[7'(k)] = 1'b1;
    end
    xm = '0; xm[19] = 1; xm[78] = 1; xm[88] = 1; xm[98] = 1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL bounce_pulses got=%h want=%h", pm, xm); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pm, xm;
    do_reset();
    pm = '0;
    for (int k = 0; k < 60; k++) begin
      Btn = 5'b00100;
      Reset = (k == 10 || k == 11);
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL reset_deb_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Down) pm[7'(k)] = 1'b1;
    end
    Reset = 1'b0;
    xm = '0; xm[31] = 1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL reset_deb_pulses got=%h want=%h", pm, xm); end
    do_reset();
    pm = '0;
    for (int k = 0; k < 80; k++) begin
      Btn = 5'b00001;
      Reset = (k == 68);
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL reset_rpt_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
      if (Right) pm[7'(k)] = 1'b1;
    end
    Reset = 1'b0;
    xm = '0; xm[19] = 1; xm[59] = 1;
    n_cmp++;
    if (pm !== xm) begin n_bad++; $display("FAIL reset_rpt_pulses got=%h want=%h", pm, xm); end
  endtask

  task automatic test_random();
    int left [5];
    do_reset();
    for (int i = 0; i < 5; i++) left[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (left[i] == 0) begin
          Btn[3'(i)] = 1'($urandom);
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120))
                                                 : int'($urandom_range(1, 25));
        end
        left[i]--;
      end
      Reset = ($urandom_range(0, 299) == 0);
      step();
      n_cmp++;
      if ({obs_p, Evt, EvtCode, Held} !== {e_p, e_evt, e_code, e_held}) begin
        n_bad++; $display("FAIL random_model k=%0d got=%b want=%b", k,
                          {obs_p, Evt, EvtCode, Held}, {e_p, e_evt, e_code, e_held});
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_up();
    test_glitch();
    test_repeat();
    test_back_to_back();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
